// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency/phase sweep sequencer for the DDS core.
// Accepts one sweep descriptor over a valid/ready handshake and then steps
// the frequency word K from start toward stop. Each point is held for a
// programmable dwell. Supported modes are single sweep, repeating sawtooth
// and continuous triangle.
// Optional build feature: define DDS_SWEEP_PHASE_STEP_EN to add cfg_p_step.
// P then advances by p_step (mod 2^PW) on every STEP that changes K.
module dds_sweep_ctrl #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [KW-1:0] cfg_k_start,
  input  logic [KW-1:0] cfg_k_stop,
  input  logic [KW-1:0] cfg_k_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  input  logic [PW-1:0] cfg_phase,
`ifdef DDS_SWEEP_PHASE_STEP_EN
  input  logic [PW-1:0] cfg_p_step,
`endif
  input  logic          abort,
  output logic [KW-1:0] K,
  output logic [PW-1:0] P,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DWELL  = 2'd1,
    ST_STEP   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic       DIR_UP      = 1'b0;
  localparam logic       DIR_DOWN    = 1'b1;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [PW-1:0]   p_q, p_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;

  // Latched descriptor. It is only written on acceptance, so later cfg_* changes are ignored.
  logic [KW-1:0]   start_q;
  logic [KW-1:0]   stop_q;
  logic [KW-1:0]   step_q;
  logic [DW-1:0]   dwell_q;
  logic [1:0]      mode_q;
`ifdef DDS_SWEEP_PHASE_STEP_EN
  logic [PW-1:0]   p_step_q;
`endif

  logic            ready_q;
  logic            busy_q;
  logic            done_q;

  logic            accept_s;
  logic [KW:0]     sum_s;
  logic [KW:0]     diff_s;
  logic            step_nz_s;
  logic            up_fit_s;
  logic            down_fit_s;
  logic [KW-1:0]   up_clamp_s;
  logic [KW-1:0]   down_clamp_s;

  assign accept_s  = cfg_valid & (state_q == ST_IDLE);

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign K         = k_q;
  assign P         = p_q;

  // Capture the descriptor on handshake; an inverted range collapses to a single point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      mode_q   <= MODE_SINGLE;
`ifdef DDS_SWEEP_PHASE_STEP_EN
      p_step_q <= '0;
`endif
    end else if (accept_s) begin
      start_q  <= cfg_k_start;
      stop_q   <= (cfg_k_start > cfg_k_stop) ? cfg_k_start : cfg_k_stop;
      step_q   <= cfg_k_step;
      dwell_q  <= cfg_dwell;
      mode_q   <= (cfg_mode == 2'd3) ? MODE_SINGLE : cfg_mode;
`ifdef DDS_SWEEP_PHASE_STEP_EN
      p_step_q <= cfg_p_step;
`endif
    end else begin
      start_q  <= start_q;
      stop_q   <= stop_q;
      step_q   <= step_q;
      dwell_q  <= dwell_q;
      mode_q   <= mode_q;
`ifdef DDS_SWEEP_PHASE_STEP_EN
      p_step_q <= p_step_q;
`endif
    end
  end

  // Next-point arithmetic at KW+1 bits so carry/borrow past the word range is visible.
  always_comb begin
    sum_s        = {1'b0, k_q} + {1'b0, step_q};
    diff_s       = {1'b0, k_q} - {1'b0, step_q};
    step_nz_s    = (step_q != '0);
    up_fit_s     = ~sum_s[KW] & (sum_s[KW-1:0] <= stop_q);
    down_fit_s   = ~diff_s[KW] & (diff_s[KW-1:0] >= start_q);
    up_clamp_s   = up_fit_s ? sum_s[KW-1:0] : stop_q;
    down_clamp_s = down_fit_s ? diff_s[KW-1:0] : start_q;
  end

  // Sweep sequencer: next state, next K/P, dwell counter and direction.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    case (state_q)
      ST_IDLE: begin
        // abort is deliberately ignored here, even together with cfg_valid.
        if (cfg_valid) begin
          state_d = ST_DWELL;
          k_d     = cfg_k_start;
          p_d     = cfg_phase;
          cnt_d   = cfg_dwell;
          dir_d   = DIR_UP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DWELL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_STEP;
        end else begin
          cnt_d = cnt_q - {{(DW-1){1'b0}}, 1'b1};
        end
      end

      ST_STEP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = dwell_q;
          state_d = ST_DWELL;
          if (dir_q == DIR_UP) begin
            if (up_fit_s && step_nz_s) begin
              k_d = sum_s[KW-1:0];
            end else begin
              // Upper bound reached (a zero step counts as reaching it).
              case (mode_q)
                MODE_SINGLE: begin
                  state_d = ST_FINISH;
                end
                MODE_SAW: begin
                  k_d = start_q;
                end
                MODE_TRI: begin
                  // Turn around without repeating the stop value.
                  dir_d = DIR_DOWN;
                  k_d   = down_clamp_s;
                end
                default: begin
                  state_d = ST_FINISH;
                end
              endcase
            end
          end else begin
            if (down_fit_s && step_nz_s) begin
              k_d = diff_s[KW-1:0];
            end else begin
              // Lower bound reached: head back up without repeating start.
              dir_d = DIR_UP;
              k_d   = up_clamp_s;
            end
          end

          if ((state_d == ST_DWELL) && (k_d != k_q)) begin
`ifdef DDS_SWEEP_PHASE_STEP_EN
            p_d = p_q + p_step_q;
`else
            p_d = p_q;
`endif
          end else begin
            p_d = p_q;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state; K and P keep their values on finish and abort so the DDS keeps running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Status outputs registered from the next state, so they are Moore decodes of state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_FINISH);
    end
  end

endmodule
